// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU op codes, opcode/funct values, forwarding selects
// and the EX control bundle.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_SX,
        IMM_ZX,
        IMM_SHAMT,
        IMM_LUI
    } imm_kind_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_decoder.sv
// Combinational opcode/funct decode into ALU op, control bits, immediate kind
// and destination field select.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_op,
    output ex_ctrl_t   o_ctrl,
    output imm_kind_e  o_imm_kind,
    output logic       o_dest_rd,
    output logic       o_illegal
);

    always_comb begin
        o_op       = ALU_AND;
        o_ctrl     = '0;
        o_imm_kind = IMM_NONE;
        o_dest_rd  = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OPC_RTYPE: begin
                o_dest_rd        = 1'b1;
                o_ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_op = ALU_ADD;
                    FN_SUB, FN_SUBU: o_op = ALU_SUB;
                    FN_AND:          o_op = ALU_AND;
                    FN_OR:           o_op = ALU_OR;
                    FN_NOR:          o_op = ALU_NOR;
                    FN_SLT:          o_op = ALU_SLT;
                    FN_SLL: begin
                        o_op       = ALU_SLL;
                        o_imm_kind = IMM_SHAMT;
                    end
                    default:         o_illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_ADDIU: begin
                o_op = ALU_ADD; o_imm_kind = IMM_SX; o_ctrl.reg_write = 1'b1;
            end
            OPC_SLTI: begin
                o_op = ALU_SLT; o_imm_kind = IMM_SX; o_ctrl.reg_write = 1'b1;
            end
            OPC_ANDI: begin
                o_op = ALU_AND; o_imm_kind = IMM_ZX; o_ctrl.reg_write = 1'b1;
            end
            OPC_ORI: begin
                o_op = ALU_OR; o_imm_kind = IMM_ZX; o_ctrl.reg_write = 1'b1;
            end
            OPC_LUI: begin
                o_op = ALU_SLL; o_imm_kind = IMM_LUI; o_ctrl.reg_write = 1'b1;
            end
            OPC_LW: begin
                o_op = ALU_ADD; o_imm_kind = IMM_SX;
                o_ctrl.reg_write = 1'b1; o_ctrl.mem_read = 1'b1;
            end
            OPC_SW: begin
                o_op = ALU_ADD; o_imm_kind = IMM_SX; o_ctrl.mem_write = 1'b1;
            end
            OPC_BEQ: begin
                o_op = ALU_SUB; o_ctrl.branch = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
        // An unrecognised R-type funct must not leak the R-type defaults.
        if (o_illegal) begin
            o_op       = ALU_AND;
            o_ctrl     = '0;
            o_imm_kind = IMM_NONE;
            o_dest_rd  = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarding, operand selection and EX control bundle.
// Define FORWARD_EN to build the rs/rt forwarding muxes; otherwise regfile reads pass straight through.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [3:0]  ex_op,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_illegal
);

    logic [31:0] w_fa, w_fb, w_a, w_b;
    logic [15:0] w_imm;
    logic [4:0]  w_dest;
    logic [3:0]  w_op;
    ex_ctrl_t    w_ctrl;
    imm_kind_e   w_imm_kind;
    logic        w_dest_rd, w_illegal, w_load;
    logic        w_unused_rs_field;

    ex_ctrl_t    r_ctrl;

    assign w_imm             = id_instr[15:0];
    assign w_unused_rs_field = ^id_instr[25:21];

`ifdef FORWARD_EN
    always_comb begin
        case (fwd_a_sel)
            FWD_EXMEM: w_fa = exmem_result;
            FWD_MEMWB: w_fa = memwb_result;
            default:   w_fa = id_rs_data;
        endcase
        case (fwd_b_sel)
            FWD_EXMEM: w_fb = exmem_result;
            FWD_MEMWB: w_fb = memwb_result;
            default:   w_fb = id_rt_data;
        endcase
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_a_sel, fwd_b_sel, exmem_result, memwb_result};
    assign w_fa = id_rs_data;
    assign w_fb = id_rt_data;
`endif

    alu_decoder u_dec (
        .i_opcode   (id_instr[31:26]),
        .i_funct    (id_instr[5:0]),
        .o_op       (w_op),
        .o_ctrl     (w_ctrl),
        .o_imm_kind (w_imm_kind),
        .o_dest_rd  (w_dest_rd),
        .o_illegal  (w_illegal)
    );

    always_comb begin
        w_a = w_fa;
        w_b = w_fb;
        case (w_imm_kind)
            IMM_SX:    w_b = sext16(w_imm);
            IMM_ZX:    w_b = {16'h0000, w_imm};
            IMM_SHAMT: begin
                w_a = w_fb;
                w_b = {27'd0, id_instr[10:6]};
            end
            IMM_LUI:   begin
                w_a = {16'h0000, w_imm};
                w_b = 32'd16;
            end
            default:   ;
        endcase
        if (w_illegal) begin
            w_a = '0;
            w_b = '0;
        end
    end

    assign w_dest = w_illegal ? 5'd0 : (w_dest_rd ? id_instr[15:11] : id_instr[20:16]);

    // A load cycle with no real instruction, or any flush, writes a bubble.
    assign w_load = id_valid && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_A          <= '0;
            ex_B          <= '0;
            ex_op         <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            r_ctrl        <= '0;
            ex_illegal    <= 1'b0;
        end else if (flush || !stall) begin
            ex_valid      <= w_load;
            ex_A          <= w_load ? w_a : '0;
            ex_B          <= w_load ? w_b : '0;
            ex_op         <= w_load ? w_op : '0;
            ex_store_data <= w_load ? w_fb : '0;
            ex_dest       <= w_load ? w_dest : '0;
            r_ctrl        <= w_load ? w_ctrl : '0;
            ex_illegal    <= w_load && w_illegal;
        end
    end

    assign ex_reg_write = r_ctrl.reg_write;
    assign ex_mem_read  = r_ctrl.mem_read;
    assign ex_mem_write = r_ctrl.mem_write;
    assign ex_branch    = r_ctrl.branch;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Registered ID/EX pipeline stage of the MIPS core. It sits directly upstream of the ALU. Each cycle it takes a decoded-stage instruction and its register-file operands, and translates opcode/funct into the 4-bit ALU op. It selects and forwards operands, then registers A, B, op and the downstream control bits that the EX stage and ALU consume. Stall and flush inputs from the hazard unit hold the stage or turn it into a bubble.

## Interface
- No parameters; data width fixed at 32, ALU op width at 4.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word
- id_rs_data  in  32  register-file read of rs
- id_rt_data  in  32  register-file read of rt
- fwd_a_sel  in  2  rs source: 00 regfile, 01 exmem_result, 10 memwb_result, 11 regfile
- fwd_b_sel  in  2  rt source, same encoding
- exmem_result  in  32  EX/MEM forwarding value
- memwb_result  in  32  MEM/WB forwarding value
- ex_valid  out  1  stage holds a real instruction
- ex_A  out  32  ALU operand A
- ex_B  out  32  ALU operand B
- ex_op  out  4  ALU op
- ex_store_data  out  32  forwarded rt, for sw
- ex_dest  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  control bits
- ex_illegal  out  1  unrecognised instruction

## Operation
- Operand forwarding: forwarded rs (fa) and forwarded rt (fb) are selected by fwd_*_sel before operand selection.
- Immediates: sign-extension is sx(imm16); zero-extension is zx(imm16).
- R-type (opcode 0x00), dest = rd, reg_write = 1:
  - funct 0x20/0x21 → op 2: A=fa, B=fb
  - funct 0x22/0x23 → op 6: A=fa, B=fb
  - funct 0x24 → op 0; 0x25 → op 1; 0x27 → op 12; 0x2A → op 7
  - funct 0x00 (sll) → op 3: A=fb, B=zx(shamt)
- I-type, dest = rt:
  - addi 0x08, addiu 0x09 → op 2, B=sx
  - slti 0x0A → op 7, B=sx
  - andi 0x0C → op 0, B=zx
  - ori 0x0D → op 1, B=zx
  - lui 0x0F → op 3: A=zx(imm16), B=16
  - lw 0x23 → op 2, B=sx, mem_read=1
  - sw 0x2B → op 2, B=sx, mem_write=1, reg_write=0
  - beq 0x04 → op 6: A=fa, B=fb, branch=1, reg_write=0
  - For all of the above except lui, A=fa.
- Any other opcode or funct: ex_illegal=1, ex_op=0, all control bits 0. ex_valid follows id_valid.
- ex_store_data = fb for every instruction.
- Bubble: all outputs 0.
- When id_valid=0, the stage loads a bubble.

## Timing
- All outputs are registered; latency is one cycle from ID inputs to EX outputs.
- Register-update priority at each clk edge:
  - reset (asynchronous): every output 0
  - else flush: bubble
  - else stall: hold all registers unchanged
  - else load the decoded instruction
- flush together with stall: flush wins.
- During stall, forwarding inputs are not re-sampled; the hazard unit is responsible for operand correctness on release.
- Reset mid-stream: outputs clear immediately and asynchronously. The first load occurs at the first clk edge after reset deasserts.

## Configuration
- FORWARD_EN defined: forwarding muxes are present as described.
- FORWARD_EN undefined:
  - fa = id_rs_data, fb = id_rt_data
  - fwd_a_sel, fwd_b_sel, exmem_result and memwb_result are ignored
  - all other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - ALU op constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12
  - opcode and funct localparams
  - forwarding-select encoding
  - a packed struct for the EX control bundle
- One sub-module, alu_decoder: combinational opcode/funct → {op, control bits, immediate kind, illegal}.
- id_ex_stage owns forwarding, operand selection and the pipeline registers.

## Test plan
- reset=1 with arbitrary inputs → all outputs 0. Release reset, apply add $3,$1,$2 (0x00221820) with rs=5, rt=7 → next cycle: ex_op=2, A=5, B=7, ex_dest=3, reg_write=1, valid=1.
- lui $4,0x1234 → A=0x00001234, B=16, op=3, dest=4. ori with imm 0xFFFF → B=0x0000FFFF. addi with imm 0xFFFF → B=0xFFFFFFFF.
- With FORWARD_EN: fwd_a_sel=01, exmem_result=0xAA → A=0xAA. fwd_b_sel=10 on sw → ex_store_data=memwb_result, B=sx(imm), mem_write=1, reg_write=0.
- Load beq, then stall=1 for 3 cycles while inputs change → outputs frozen at beq values (op=6, branch=1). stall+flush together → bubble (all 0).
- opcode 0x3F and R-type funct 0x3F → illegal=1, op=0, control bits 0, valid=1. Same instruction with id_valid=0 → full bubble.
- sll $2,$3,4 (0x00031100), rt=0x1 → A=1, B=4, op=3, dest=2.
